st1_fetch_stage: RTL and testbench

Stage 1 of the 16-bit pipelined datapath. Holds the program counter and fetches one 16-bit instruction per cycle from an external instruction memory. It captures the instruction into the IF/ID pipeline register and presents decoded register-select fields and the opcode directly to the stage-2 register file. It supports stage-2 stall, branch redirect, and instruction-memory wait states.

---
 rtl/st1_fetch_stage.sv | 82 ++++++++
 tb/tb_st1_fetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/st1_fetch_stage.sv
// Pipeline stage 1: PC, instruction fetch and IF/ID register feeding the stage-2 register file.
// Optional macro ST1_FETCH_CNT_EN adds a saturating count of accepted fetches on fetch_count.
module st1_fetch_stage #(
    parameter int unsigned         PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned         INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_ready,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc_plus2,
    output logic                   if_id_valid,
    output logic [3:0]             Opcode,
    output logic [3:0]             ReadReg1,
    output logic [3:0]             ReadReg2
`ifdef ST1_FETCH_CNT_EN
    ,
    output logic [15:0]            fetch_count
`endif
);

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pcPlus2;
    logic [PC_WIDTH-1:0] redirectPc;
    logic                accept;

    always_comb begin
        pcPlus2    = pc + PC_WIDTH'(2);
        redirectPc = {branch_target[PC_WIDTH-1:1], 1'b0};
        accept     = !branch_taken && !stall && imem_ready;
        imem_addr  = pc;
        Opcode     = if_id_instr[15:12];
        ReadReg1   = if_id_instr[11:8];
        ReadReg2   = if_id_instr[7:4];
    end

    // Redirect beats stall, stall beats a memory wait, so a stalled IF/ID is never bubbled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            if_id_instr    <= '0;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
        end else if (branch_taken) begin
            pc             <= redirectPc;
            if_id_instr    <= '0;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
        end else if (stall) begin
            pc             <= pc;
        end else if (!imem_ready) begin
            if_id_instr    <= '0;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            pc             <= pcPlus2;
            if_id_instr    <= imem_rdata;
            if_id_pc_plus2 <= pcPlus2;
            if_id_valid    <= 1'b1;
        end
    end

`ifdef ST1_FETCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (accept && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`else
    logic unusedAccept;
    assign unusedAccept = accept;
`endif

endmodule

// File: tb/tb_st1_fetch_stage.sv
// Directed self-checking bench for st1_fetch_stage; fetch-counter checks build when ST1_FETCH_CNT_EN is defined.
module tb_st1_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic [15:0] imemAddr;
    logic [15:0] imemRdata;
    logic        imemReady;
    logic [15:0] ifIdInstr;
    logic [15:0] ifIdPcPlus2;
    logic        ifIdValid;
    logic [3:0]  opcode;
    logic [3:0]  readReg1;
    logic [3:0]  readReg2;
`ifdef ST1_FETCH_CNT_EN
    logic [15:0] fetchCount;
`endif

    int passCount  = 0;
    int totalCount = 0;

    st1_fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branchTaken),
        .branch_target  (branchTarget),
        .imem_addr      (imemAddr),
        .imem_rdata     (imemRdata),
        .imem_ready     (imemReady),
        .if_id_instr    (ifIdInstr),
        .if_id_pc_plus2 (ifIdPcPlus2),
        .if_id_valid    (ifIdValid),
        .Opcode         (opcode),
        .ReadReg1       (readReg1),
        .ReadReg2       (readReg2)
`ifdef ST1_FETCH_CNT_EN
        ,
        .fetch_count    (fetchCount)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: two fixed words, otherwise 7 followed by the low 12 address bits.
    always_comb begin
        case (imemAddr)
            16'h0000: imemRdata = 16'h1230;
            16'h0002: imemRdata = 16'h4560;
            default:  imemRdata = {4'h7, imemAddr[11:0]};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0; imemReady = 1'b1;
        tick();
        totalCount++; if (imemAddr !== 16'h0000) $display("FAIL reset_addr got=%h exp=0000", imemAddr); else passCount++;
        totalCount++; if (ifIdValid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ifIdValid); else passCount++;
        totalCount++; if ({opcode, readReg1, readReg2} !== 12'h000) $display("FAIL reset_fields got=%h exp=000", {opcode, readReg1, readReg2}); else passCount++;
        totalCount++; if (ifIdPcPlus2 !== 16'h0000) $display("FAIL reset_pcplus2 got=%h exp=0000", ifIdPcPlus2); else passCount++;
        rst = 1'b0;
        tick();
        totalCount++; if (ifIdInstr !== 16'h1230) $display("FAIL first_instr got=%h exp=1230", ifIdInstr); else passCount++;
        totalCount++; if (ifIdPcPlus2 !== 16'h0002) $display("FAIL first_pcplus2 got=%h exp=0002", ifIdPcPlus2); else passCount++;
        totalCount++; if ({readReg1, readReg2} !== 8'h23) $display("FAIL first_regs got=%h exp=23", {readReg1, readReg2}); else passCount++;
        totalCount++; if (ifIdValid !== 1'b1) $display("FAIL first_valid got=%b exp=1", ifIdValid); else passCount++;
        tick();
        totalCount++; if (ifIdInstr !== 16'h4560) $display("FAIL second_instr got=%h exp=4560", ifIdInstr); else passCount++;
        totalCount++; if (imemAddr !== 16'h0004) $display("FAIL second_addr got=%h exp=0004", imemAddr); else passCount++;
    endtask

    task automatic test_stall();
        tick();
        totalCount++; if (ifIdInstr !== 16'h7004) $display("FAIL pre_stall_instr got=%h exp=7004", ifIdInstr); else passCount++;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            totalCount++; if (imemAddr !== 16'h0006) $display("FAIL stall_addr[%0d] got=%h exp=0006", i, imemAddr); else passCount++;
            totalCount++; if (ifIdInstr !== 16'h7004 || ifIdValid !== 1'b1) $display("FAIL stall_instr[%0d] got=%h/%b exp=7004/1", i, ifIdInstr, ifIdValid); else passCount++;
        end
        stall = 1'b0;
        tick();
        totalCount++; if (ifIdInstr !== 16'h7006) $display("FAIL resume_instr got=%h exp=7006", ifIdInstr); else passCount++;
        totalCount++; if (ifIdPcPlus2 !== 16'h0008) $display("FAIL resume_pcplus2 got=%h exp=0008", ifIdPcPlus2); else passCount++;
    endtask

    task automatic test_branch();
        branchTaken = 1'b1; branchTarget = 16'h0041;
        tick();
        totalCount++; if (imemAddr !== 16'h0040) $display("FAIL branch_addr got=%h exp=0040", imemAddr); else passCount++;
        totalCount++; if (ifIdValid !== 1'b0 || opcode !== 4'h0 || ifIdInstr !== 16'h0000) $display("FAIL branch_bubble got=%b/%h/%h exp=0/0/0000", ifIdValid, opcode, ifIdInstr); else passCount++;
        branchTaken = 1'b0;
        tick();
        totalCount++; if (ifIdInstr !== 16'h7040 || ifIdPcPlus2 !== 16'h0042) $display("FAIL target_fetch got=%h/%h exp=7040/0042", ifIdInstr, ifIdPcPlus2); else passCount++;
        // redirect must override a simultaneous stall and memory wait
        branchTaken = 1'b1; branchTarget = 16'h0010; stall = 1'b1; imemReady = 1'b0;
        tick();
        totalCount++; if (imemAddr !== 16'h0010 || ifIdValid !== 1'b0) $display("FAIL branch_over_stall got=%h/%b exp=0010/0", imemAddr, ifIdValid); else passCount++;
        branchTaken = 1'b0; stall = 1'b0; imemReady = 1'b1;
        tick();
        totalCount++; if (ifIdInstr !== 16'h7010 || imemAddr !== 16'h0012) $display("FAIL after_branch got=%h/%h exp=7010/0012", ifIdInstr, imemAddr); else passCount++;
    endtask

    task automatic test_wait();
        tick();
        totalCount++; if (ifIdInstr !== 16'h7012) $display("FAIL pre_wait_instr got=%h exp=7012", ifIdInstr); else passCount++;
        stall = 1'b1; imemReady = 1'b0;
        tick();
        totalCount++; if (ifIdValid !== 1'b1 || ifIdInstr !== 16'h7012 || imemAddr !== 16'h0014) $display("FAIL stall_over_wait got=%b/%h/%h exp=1/7012/0014", ifIdValid, ifIdInstr, imemAddr); else passCount++;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            totalCount++; if (ifIdValid !== 1'b0 || imemAddr !== 16'h0014 || ifIdInstr !== 16'h0000) $display("FAIL wait_bubble[%0d] got=%b/%h/%h exp=0/0014/0000", i, ifIdValid, imemAddr, ifIdInstr); else passCount++;
        end
        imemReady = 1'b1;
        tick();
        totalCount++; if (ifIdInstr !== 16'h7014 || ifIdPcPlus2 !== 16'h0016) $display("FAIL post_wait got=%h/%h exp=7014/0016", ifIdInstr, ifIdPcPlus2); else passCount++;
    endtask

    task automatic test_wrap();
        branchTaken = 1'b1; branchTarget = 16'hFFFE;
        tick();
        branchTaken = 1'b0;
        totalCount++; if (imemAddr !== 16'hFFFE) $display("FAIL wrap_setup got=%h exp=fffe", imemAddr); else passCount++;
        tick();
        totalCount++; if (imemAddr !== 16'h0000 || ifIdPcPlus2 !== 16'h0000) $display("FAIL wrap got=%h/%h exp=0000/0000", imemAddr, ifIdPcPlus2); else passCount++;
        totalCount++; if (ifIdInstr !== 16'h7FFE) $display("FAIL wrap_instr got=%h exp=7ffe", ifIdInstr); else passCount++;
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        stall = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        totalCount++; if (imemAddr !== 16'h0000 || ifIdValid !== 1'b0 || ifIdInstr !== 16'h0000 || ifIdPcPlus2 !== 16'h0000) $display("FAIL async_reset got=%h/%b/%h/%h exp=0000/0/0000/0000", imemAddr, ifIdValid, ifIdInstr, ifIdPcPlus2); else passCount++;
        tick();
        rst = 1'b0; stall = 1'b0;
        tick();
        totalCount++; if (ifIdInstr !== 16'h1230 || ifIdPcPlus2 !== 16'h0002) $display("FAIL after_reset got=%h/%h exp=1230/0002", ifIdInstr, ifIdPcPlus2); else passCount++;
    endtask

`ifdef ST1_FETCH_CNT_EN
    task automatic test_fetch_count();
        rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; imemReady = 1'b1;
        tick();
        totalCount++; if (fetchCount !== 16'h0000) $display("FAIL count_reset got=%h exp=0000", fetchCount); else passCount++;
        rst = 1'b0;
        tick(); tick(); tick();
        stall = 1'b1; tick(); tick(); stall = 1'b0;
        branchTaken = 1'b1; branchTarget = 16'h0100; tick(); branchTaken = 1'b0;
        imemReady = 1'b0; tick(); imemReady = 1'b1;
        tick(); tick();
        totalCount++; if (fetchCount !== 16'd5) $display("FAIL count_mixed got=%0d exp=5", fetchCount); else passCount++;
        for (int i = 0; i < 65530; i++) @(posedge clk);
        #1;
        totalCount++; if (fetchCount !== 16'hFFFF) $display("FAIL count_full got=%h exp=ffff", fetchCount); else passCount++;
        tick(); tick(); tick();
        totalCount++; if (fetchCount !== 16'hFFFF) $display("FAIL count_saturate got=%h exp=ffff", fetchCount); else passCount++;
    endtask
`endif

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_wait();
        test_wrap();
        test_async_reset();
`ifdef ST1_FETCH_CNT_EN
        test_fetch_count();
`endif
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
